// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory fetch sequencer.
package imem_pkg;

  localparam int unsigned AW_DEF = 10;
  localparam int unsigned DW_DEF = 32;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2,
    ST_HALT = 2'd3
  } state_e;

endpackage

// File: rtl/imem_port_mux.sv
// Selects whether the single memory port serves instruction fetch or the program loader.
module imem_port_mux
  import imem_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  state_e          state_i,
  input  logic [AW-1:0]   pc_i,
  input  logic            ld_req_i,
  input  logic [AW-1:0]   ld_addr_i,
  input  logic [DW-1:0]   ld_data_i,
  output logic            ld_gnt,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata
);

  always_comb begin
    mem_addr  = pc_i;
    mem_we    = 1'b0;
    mem_wdata = '0;
    ld_gnt    = 1'b0;
    if (state_i == ST_LOAD) begin
      mem_addr  = ld_addr_i;
      mem_wdata = ld_data_i;
      mem_we    = ld_req_i;
      ld_gnt    = ld_req_i;
    end
  end

endmodule

// File: rtl/imem_fetch_sequencer.sv
// PC owner and fetch/loader sequencer for a single-port instruction memory.
// Optional halt-word detection is enabled by defining IMEM_FETCH_HALT_DETECT_EN.
module imem_fetch_sequencer
  import imem_pkg::*;
#(
  parameter int unsigned    AW        = AW_DEF,
  parameter int unsigned    DW        = DW_DEF,
  parameter logic [AW-1:0]  RESET_PC  = '0,
  parameter logic [DW-1:0]  HALT_WORD = DW'(HALT_WORD_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [AW-1:0]   redirect_pc,
  input  logic            ld_req,
  input  logic [AW-1:0]   ld_addr,
  input  logic [DW-1:0]   ld_data,
  output logic            ld_gnt,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            if_valid,
  output logic [AW-1:0]   if_pc,
  output logic [DW-1:0]   if_instr,
  output logic [1:0]      state
);

`ifdef IMEM_FETCH_HALT_DETECT_EN
  localparam bit HALT_DET_EN = 1'b1;
`else
  localparam bit HALT_DET_EN = 1'b0;
`endif

  state_e          state_q, state_d;
  state_e          ret_q, ret_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic            if_valid_q, if_valid_d;
  logic [AW-1:0]   if_pc_q, if_pc_d;
  logic [DW-1:0]   if_instr_q, if_instr_d;
  logic            halt_hit_c;

  assign halt_hit_c = HALT_DET_EN && (mem_rdata == HALT_WORD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ret_q      <= ST_IDLE;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  // Next-state: loader beats redirect, redirect beats stall, stall beats fetch.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    case (state_q)
      ST_IDLE: begin
        if (ld_req) begin
          state_d = ST_LOAD;
          ret_d   = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end
      end
      ST_RUN: begin
        if (ld_req) begin
          state_d    = ST_LOAD;
          ret_d      = ST_RUN;
          if_valid_d = 1'b0;
          if (redirect_valid) pc_d = redirect_pc;
        end else if (redirect_valid) begin
          pc_d       = redirect_pc;
          if_valid_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (halt_hit_c) begin
          state_d    = ST_HALT;
          if_valid_d = 1'b0;
        end else begin
          if_instr_d = mem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + AW'(1);
        end
      end
      ST_LOAD: begin
        if_valid_d = 1'b0;
        if (!ld_req) state_d = ret_q;
      end
      ST_HALT: begin
        if (ld_req) begin
          state_d = ST_LOAD;
          ret_d   = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end
      end
    endcase
  end

  imem_port_mux #(
    .AW (AW),
    .DW (DW)
  ) u_port_mux (
    .state_i   (state_q),
    .pc_i      (pc_q),
    .ld_req_i  (ld_req),
    .ld_addr_i (ld_addr),
    .ld_data_i (ld_data),
    .ld_gnt    (ld_gnt),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;
  assign state    = state_q;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed bench for imem_fetch_sequencer with a behavioural single-port memory.
module tb_imem_fetch_sequencer;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stall;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_gnt;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          if_valid;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_instr;
  logic [1:0]    state;

  logic [DW-1:0] mem [1024];

  int n_assert = 0;
  int n_fail   = 0;
  int gnt_cnt  = 0;

  imem_fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ld_req         (ld_req),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .ld_gnt         (ld_gnt),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .state          (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
  end

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] instr);
    chk({tag, "_valid"}, 32'(if_valid), 32'(v));
    chk({tag, "_pc"}, 32'(if_pc), pc);
    chk({tag, "_instr"}, if_instr, instr);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; ld_req = 1'b0; ld_addr = '0; ld_data = '0;
    #3;
    chk("rst_state", 32'(state), 32'd0);
    chk_if("rst", 1'b0, 32'd0, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_gnt", 32'(ld_gnt), 32'd0);
    tick(); tick();
    rst = 1'b1;

    // Boot load of addresses 0..7
    ld_req = 1'b1; ld_addr = '0; ld_data = 32'h1000_0000;
    #1;
    chk("idle_no_gnt", 32'(ld_gnt), 32'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      ld_addr = AW'(i);
      ld_data = 32'h1000_0000 + i;
      #1;
      if (ld_gnt) gnt_cnt++;
      chk("boot_we", 32'(mem_we), 32'd1);
      chk("boot_addr", 32'(mem_addr), 32'(i));
      tick();
    end
    ld_req = 1'b0;
    #1;
    if (ld_gnt) gnt_cnt++;
    chk("boot_gnt_count", 32'(gnt_cnt), 32'd8);
    tick();
    chk("boot_back_idle", 32'(state), 32'd0);

    // Start and sequential fetch
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_run", 32'(state), 32'd1);
    chk("start_first_invalid", 32'(if_valid), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk_if("seq", 1'b1, 32'(k), 32'h1000_0000 + k);
      tick();
    end

    // Stall at pc=5 for three cycles, then redirect to 2 under stall
    chk("pre_stall_addr", 32'(mem_addr), 32'd5);
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk_if("stall", 1'b1, 32'd4, 32'h1000_0004);
      chk("stall_addr", 32'(mem_addr), 32'd5);
    end
    redirect_valid = 1'b1; redirect_pc = AW'(2);
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    chk_if("squash", 1'b0, 32'd4, 32'h1000_0004);
    tick();
    chk_if("redir2", 1'b1, 32'd2, 32'h1000_0002);

    // Wrap-around from 1023
    redirect_valid = 1'b1; redirect_pc = AW'(1023);
    tick();
    redirect_valid = 1'b0;
    chk("wrap_squash", 32'(if_valid), 32'd0);
    tick();
    chk_if("wrap1023", 1'b1, 32'd1023, 32'hA000_03FF);
    tick();
    chk_if("wrap0", 1'b1, 32'd0, 32'h1000_0000);
    tick();
    chk_if("wrap1", 1'b1, 32'd1, 32'h1000_0001);

    // Mid-run load at pc=9 writing address 20
    redirect_valid = 1'b1; redirect_pc = AW'(9);
    tick();
    redirect_valid = 1'b0;
    ld_req = 1'b1; ld_addr = AW'(20); ld_data = 32'hDEAD_BEEF;
    tick();
    chk("mid_load_state", 32'(state), 32'd2);
    chk("mid_load_valid", 32'(if_valid), 32'd0);
    #1;
    chk("mid_load_we", 32'(mem_we), 32'd1);
    chk("mid_load_addr", 32'(mem_addr), 32'd20);
    tick();
    ld_data = 32'hCAFE_F00D;
    #1;
    chk("mid_load_gnt2", 32'(ld_gnt), 32'd1);
    tick();
    ld_req = 1'b0;
    chk("mid_load_valid2", 32'(if_valid), 32'd0);
    tick();
    chk("resume_state", 32'(state), 32'd1);
    chk("resume_addr", 32'(mem_addr), 32'd9);
    tick();
    chk_if("resume9", 1'b1, 32'd9, 32'hA000_0009);
    redirect_valid = 1'b1; redirect_pc = AW'(20);
    tick();
    redirect_valid = 1'b0;
    tick();
    chk_if("new_word20", 1'b1, 32'd20, 32'hCAFE_F00D);

    // Load halt word at 3, then reset while still loading
    ld_req = 1'b1; ld_addr = AW'(3); ld_data = 32'hFFFF_FFFF;
    tick();
    chk("halt_load_gnt", 32'(ld_gnt), 32'd1);
    tick();
    #1;
    chk("pre_rst_we", 32'(mem_we), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_we", 32'(mem_we), 32'd0);
    chk("rst_mid_gnt", 32'(ld_gnt), 32'd0);
    chk("rst_mid_state", 32'(state), 32'd0);
    chk("rst_mid_valid", 32'(if_valid), 32'd0);
    tick();
    rst = 1'b1; ld_req = 1'b0;

    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk_if("halt_seq", 1'b1, 32'(k), 32'h1000_0000 + k);
      tick();
    end
`ifdef IMEM_FETCH_HALT_DETECT_EN
    chk("halt_state", 32'(state), 32'd3);
    chk("halt_valid", 32'(if_valid), 32'd0);
    chk("halt_addr", 32'(mem_addr), 32'd3);
    tick();
    chk("halt_stays", 32'(state), 32'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_state", 32'(state), 32'd1);
    tick();
    chk_if("restart0", 1'b1, 32'd0, 32'h1000_0000);
`else
    chk_if("halt_word_issued", 1'b1, 32'd3, 32'hFFFF_FFFF);
    chk("no_halt_state", 32'(state), 32'd1);
    tick();
    chk_if("after_halt_word", 1'b1, 32'd4, 32'h1000_0004);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
